// File: rtl/uart_frame_parser.sv
// Assembles SYNC/ADDR/DATA/CHK command frames from the UART byte stream and
// issues register writes; bad checksums and inter-byte timeouts are dropped and counted.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 8370,
  parameter int         TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       err_chk,
  output logic       err_timeout,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]      addr_q, data_q;
  logic            ld_addr, ld_data;
  logic            pend_wr, pend_chk, pend_wr_nxt, pend_chk_nxt;
  logic            to_fire;

  always_comb begin
    state_nxt    = state;
    to_cnt_nxt   = to_cnt;
    ld_addr      = 1'b0;
    ld_data      = 1'b0;
    pend_wr_nxt  = 1'b0;
    pend_chk_nxt = 1'b0;
    to_fire      = 1'b0;
    if (state == IDLE) begin
      to_cnt_nxt = '0;
      if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ADDR;
    end else if (rx_valid) begin
      // An arriving byte always beats an expiring timer.
      to_cnt_nxt = '0;
      case (state)
        ADDR: begin ld_addr = 1'b1; state_nxt = DATA; end
        DATA: begin ld_data = 1'b1; state_nxt = CHK;  end
        default: begin
          if (rx_data == (addr_q ^ data_q ^ 8'hFF)) pend_wr_nxt = 1'b1;
          else                                      pend_chk_nxt = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end else if (to_cnt == TO_LAST) begin
      to_fire    = 1'b1;
      to_cnt_nxt = '0;
      state_nxt  = IDLE;
    end else begin
      to_cnt_nxt = to_cnt + 1'b1;
    end
  end

  // The CHK verdict is staged one cycle so the strobe lands one clk after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_wr     <= 1'b0;
      pend_chk    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      to_cnt      <= to_cnt_nxt;
      pend_wr     <= pend_wr_nxt;
      pend_chk    <= pend_chk_nxt;
      wr_en       <= pend_wr;
      err_chk     <= pend_chk;
      err_timeout <= to_fire;
      if (ld_addr) addr_q <= rx_data;
      if (ld_data) data_q <= rx_data;
      if (pend_wr) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      if ((pend_chk || to_fire) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Consumes the byte stream from the UART receive stage: an 8-bit byte plus a one-cycle valid pulse per received byte.
- Assembles 4-byte command frames: SYNC, ADDR, DATA, CHK.
- Emits a one-cycle register-write strobe with address and data for the downstream register bank.
- Discards malformed frames (bad checksum, inter-byte timeout) and counts them.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 8370, max clk cycles allowed between bytes inside a frame (about 3 byte times at 279 clk/bit).
- TO_W, 16, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte; valid only while rx_valid=1
- rx_valid  input  1  one-cycle pulse per received byte
- wr_en  output  1  one-cycle write strobe
- wr_addr  output  8  write address; held until the next write
- wr_data  output  8  write data; held until the next write
- err_chk  output  1  one-cycle pulse: checksum mismatch
- err_timeout  output  1  one-cycle pulse: inter-byte timeout
- err_count  output  8  saturating count of all frame errors
- busy  output  1  high while state is not IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; timeout counter=0.
  - wr_en=0, wr_addr=0, wr_data=0, err_chk=0, err_timeout=0, err_count=0, busy=0.
  - Reset mid-frame discards the partial frame; no error is reported.
- Byte acceptance: a byte is accepted on any clk edge with rx_valid=1. rx_valid is never back-to-back; the block still accepts every valid cycle.
- States:
  - IDLE: accept only a byte equal to SYNC_BYTE, then go to ADDR. Ignore other bytes; this is not an error.
  - ADDR: latch the byte into an internal addr register, then go to DATA. The byte is binary-transparent, so SYNC_BYTE here is an address.
  - DATA: latch the byte into an internal data register, then go to CHK.
  - CHK: compare the byte with addr ^ data ^ 8'hFF.
    - Match: at the next edge, wr_en=1 for one cycle and wr_addr/wr_data take the latched values. Go to IDLE.
    - Mismatch: at the next edge, err_chk=1 for one cycle and there is no write. Go to IDLE.
- Latency: wr_en rises one clk after the edge that accepts the CHK byte.
- Timeout:
  - The counter clears in IDLE and on every accepted byte.
  - It increments by 1 each cycle in ADDR, DATA or CHK without rx_valid.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 and rx_valid=0: go to IDLE, err_timeout=1 for one cycle, counter clears.
  - Simultaneous rx_valid and expiry: the byte wins. It is accepted normally and no timeout fires.
- err_count:
  - Increments by 1 on each err_chk or err_timeout pulse.
  - Saturates at 8'hFF and never wraps.
  - Cleared only by rst.
- busy = (state != IDLE), registered together with state.
- Pulse outputs (wr_en, err_chk, err_timeout) default to 0 on every cycle they are not explicitly asserted. At most one of them is high in any cycle.
- All outputs are registered; there are no combinational paths from the inputs.

Test Plan:
- Good frame: rx_valid pulses with bytes A5,12,34,D9, spaced 2790 clk -> one wr_en pulse, wr_addr=8'h12, wr_data=8'h34, err_count=0, busy=0 afterwards.
- Bad checksum: bytes A5,12,34,00 -> err_chk pulse one clk after the 4th byte, no wr_en, err_count=1, wr_addr/wr_data unchanged.
- Timeout (TIMEOUT_CYCLES=100): bytes A5,12, then silence -> err_timeout pulse 100 clk after the 12 byte, state IDLE. Then A5,01,02,FC -> write addr 01, data 02.
- Boundary (TIMEOUT_CYCLES=100): byte A5, then 01 arriving exactly on the expiry edge -> no err_timeout. Then 02,FC -> write addr 01, data 02.
- Garbage and sync-as-data: bytes 00,FF,5A,A5,A5,A5,FF -> ignored leading bytes; write addr A5, data A5 (chk A5^A5^FF=FF).
- Saturation and reset: 300 bad-checksum frames -> err_count=FF. Then A5,12 followed by rst -> all outputs 0, no error pulse. Then a good frame writes normally.
